// File: rtl/alu_cmd_issuer.sv
// Command FIFO plus issue FSM that drives the single-cycle tiny ALU and returns results on a valid/ready port.
// Optional macro ALU_ISSUER_TIMEOUT_EN adds a WAIT-cycle watchdog that returns an error response.
module alu_cmd_issuer #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        alu_start,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic        rsp_err,
    output logic        busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("alu_cmd_issuer: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t          state_reg, state_next;
    logic [18:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]     count_reg;
    logic            full, empty, push, pop;
    logic            done_capture, rsp_take, timeout_hit;
    logic [2:0]      head_op;
    logic [7:0]      head_a, head_b;

    assign full      = (count_reg == FULL_COUNT);
    assign empty     = (count_reg == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign busy      = (state_reg != IDLE) || !empty;
    assign {head_op, head_a, head_b} = mem[rd_ptr_reg];

    // Storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

`ifdef ALU_ISSUER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] wait_cnt_reg;
`endif

    always_comb begin
        state_next   = state_reg;
        pop          = 1'b0;
        done_capture = 1'b0;
        rsp_take     = 1'b0;
        timeout_hit  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = (head_op == 3'b000) ? HOLD : ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (alu_done) begin
                    done_capture = 1'b1;
                    state_next   = HOLD;
                end
`ifdef ALU_ISSUER_TIMEOUT_EN
                else if (wait_cnt_reg == WAIT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = HOLD;
                end
`endif
            end
            HOLD: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_take   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // A NOP enters HOLD with rsp_valid low; valid rises one cycle later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_start  <= 1'b0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_op     <= '0;
        end else begin
            alu_start <= pop && (head_op != 3'b000);
            if (pop) begin
                alu_op <= head_op;
                alu_a  <= head_a;
                alu_b  <= head_b;
            end
            if (pop && head_op == 3'b000) begin
                rsp_result <= '0;
                rsp_op     <= 3'b000;
            end
            if (done_capture) begin
                rsp_result <= alu_result;
                rsp_op     <= alu_op;
                rsp_valid  <= 1'b1;
            end
            if (timeout_hit) begin
                rsp_result <= '0;
                rsp_op     <= alu_op;
                rsp_valid  <= 1'b1;
            end
            if (state_reg == HOLD && !rsp_valid) rsp_valid <= 1'b1;
            if (rsp_take) rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_ISSUER_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_reg <= '0;
            rsp_err      <= 1'b0;
        end else begin
            if (state_reg == ISSUE)     wait_cnt_reg <= '0;
            else if (state_reg == WAIT) wait_cnt_reg <= wait_cnt_reg + 1'b1;
            if (pop || done_capture) rsp_err <= 1'b0;
            if (timeout_hit)         rsp_err <= 1'b1;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer with a behavioural single-cycle ALU answering each start one cycle later.
module tb_alu_cmd_issuer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [7:0]  cmd_a = '0;
    logic [7:0]  cmd_b = '0;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a, alu_b;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_result;
    logic [2:0]  rsp_op;
    logic        rsp_err;
    logic        busy;
    logic        no_done = 1'b0;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] result;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t exp_e;
    int   checks = 0;
    int   errors = 0;
    int   starts = 0;
    int   exp_starts = 0;

    always #5 clk = ~clk;

    alu_cmd_issuer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_op     (rsp_op),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    function automatic logic [15:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b001:  return {8'h00, a} + {8'h00, b};
            3'b010:  return {8'h00, a & b};
            3'b011:  return {8'h00, a ^ b};
            default: return 16'h0000;
        endcase
    endfunction

    // Behavioural ALU: done and result one cycle after the start pulse.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_done   <= 1'b0;
            alu_result <= '0;
        end else begin
            alu_done   <= alu_start && !no_done;
            alu_result <= alu_start ? alu_ref(alu_op, alu_a, alu_b) : 16'h0000;
        end
    end

    always @(posedge clk) begin
        if (reset_n && alu_start) starts <= starts + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check_eq("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_e = sb.pop_front();
                $display("rsp op=%0d result=%04h err=%0b (exp %04h/%0b)", rsp_op, rsp_result, rsp_err, exp_e.result, exp_e.err);
                check_eq("rsp_result", {16'h0, rsp_result}, {16'h0, exp_e.result});
                check_eq("rsp_op", {29'h0, rsp_op}, {29'h0, exp_e.op});
                check_eq("rsp_err", {31'h0, rsp_err}, {31'h0, exp_e.err});
            end
        end
    end

    task automatic push_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic err_exp);
        bit accepted;
        exp_t e;
        accepted  = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        for (int i = 0; i < 100 && !accepted; i++) begin
            @(negedge clk);
            accepted = cmd_ready;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (accepted) begin
            e.op     = op;
            e.result = err_exp ? 16'h0000 : alu_ref(op, a, b);
            e.err    = err_exp;
            sb.push_back(e);
            if (op != 3'b000) exp_starts++;
            $display("push op=%0d a=%02h b=%02h exp=%04h", op, a, b, e.result);
        end else begin
            check_eq("push_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy || rsp_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("drain_empty", sb.size(), 32'd0);
        check_eq("drain_idle", {31'h0, busy}, 32'd0);
        check_eq("start_count", starts, exp_starts);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_start"}, {31'h0, alu_start}, 32'd0);
        check_eq({tag, "_alu"}, {13'h0, alu_op, alu_a, alu_b}, 32'd0);
        check_eq({tag, "_rsp"}, {12'h0, rsp_valid, rsp_err, rsp_op, rsp_result}, 32'd0);
        check_eq({tag, "_busy"}, {31'h0, busy}, 32'd0);
        check_eq({tag, "_ready"}, {31'h0, cmd_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD with carry into bit 8, checking start/valid latency.
        push_cmd(3'b001, 8'hFF, 8'h01, 1'b0);
        check_eq("lat_start_n0", {31'h0, alu_start}, 32'd0);
        @(posedge clk); #1;
        check_eq("lat_start_n1", {31'h0, alu_start}, 32'd1);
        check_eq("lat_valid_n1", {31'h0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        check_eq("lat_start_n2", {31'h0, alu_start}, 32'd0);
        check_eq("lat_valid_n2", {31'h0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        check_eq("lat_valid_n3", {31'h0, rsp_valid}, 32'd1);
        wait_drain();

        push_cmd(3'b010, 8'hF0, 8'h3C, 1'b0);
        push_cmd(3'b011, 8'hAA, 8'h55, 1'b0);
        wait_drain();

        // NOP: no start, response after two edges.
        push_cmd(3'b000, 8'h12, 8'h34, 1'b0);
        check_eq("nop_valid_n0", {31'h0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        check_eq("nop_valid_n1", {31'h0, rsp_valid}, 32'd0);
        check_eq("nop_start_n1", {31'h0, alu_start}, 32'd0);
        @(posedge clk); #1;
        check_eq("nop_valid_n2", {31'h0, rsp_valid}, 32'd1);
        wait_drain();

        // Backpressure fills the FIFO behind the first held response.
        rsp_ready = 1'b0;
        push_cmd(3'b001, 8'h0A, 8'h14, 1'b0);
        push_cmd(3'b010, 8'h5A, 8'h0F, 1'b0);
        push_cmd(3'b011, 8'hFF, 8'h0F, 1'b0);
        push_cmd(3'b001, 8'h80, 8'h80, 1'b0);
        push_cmd(3'b000, 8'h00, 8'h00, 1'b0);
        check_eq("full_ready", {31'h0, cmd_ready}, 32'd0);
        check_eq("full_busy", {31'h0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("hold_valid", {31'h0, rsp_valid}, 32'd1);
            check_eq("hold_result", {16'h0, rsp_result}, 32'h001E);
            check_eq("hold_op", {29'h0, rsp_op}, 32'd1);
        end
        rsp_ready = 1'b1;
        wait_drain();

        // Reset while waiting on the ALU abandons the command.
        no_done = 1'b1;
        push_cmd(3'b001, 8'h33, 8'h44, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("wait_busy", {31'h0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        sb.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        no_done = 1'b0;
        push_cmd(3'b011, 8'h0F, 8'hF0, 1'b0);
        wait_drain();

`ifdef ALU_ISSUER_TIMEOUT_EN
        no_done = 1'b1;
        push_cmd(3'b001, 8'h01, 8'h02, 1'b1);
        repeat (16) @(posedge clk);
        #1;
        check_eq("to_valid_early", {31'h0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        check_eq("to_valid", {31'h0, rsp_valid}, 32'd1);
        check_eq("to_err", {31'h0, rsp_err}, 32'd1);
        no_done = 1'b0;
        wait_drain();
`else
        no_done = 1'b1;
        push_cmd(3'b001, 8'h01, 8'h02, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        check_eq("nto_valid", {31'h0, rsp_valid}, 32'd0);
        check_eq("nto_busy", {31'h0, busy}, 32'd1);
        check_eq("nto_err", {31'h0, rsp_err}, 32'd0);
        reset_n = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        no_done = 1'b0;
`endif

        // Random commands with random response backpressure.
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    push_cmd(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
                end
            end
            begin
                repeat (150) begin
                    @(posedge clk); #1;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        rsp_ready = 1'b1;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Initiator-side driver for the single-cycle tiny ALU. It buffers operation commands in a small FIFO and issues each one to the ALU as a single start pulse with operands and opcode. It then waits for the ALU done flag, captures the 16-bit result and returns it on a valid/ready response port. It sits between the test/host command source and the ALU instance.

Parameters:
DEPTH, 4, command FIFO depth in entries; power of two, minimum 2.
TIMEOUT_CYCLES, 15, number of WAIT cycles without done before an error response is returned (used only with the optional feature).

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command push request
cmd_ready  output  1  FIFO can accept a command (= not full)
cmd_op  input  3  opcode: 001 ADD, 010 AND, 011 XOR, 000 NOP, others undefined
cmd_a  input  8  operand A
cmd_b  input  8  operand B
alu_start  output  1  one-cycle start pulse to the ALU
alu_op  output  3  opcode driven to the ALU
alu_a  output  8  operand A to the ALU
alu_b  output  8  operand B to the ALU
alu_done  input  1  ALU done flag
alu_result  input  16  ALU result
rsp_valid  output  1  response available
rsp_ready  input  1  response consumer ready
rsp_result  output  16  captured result
rsp_op  output  3  opcode of the completed command
rsp_err  output  1  response is a timeout error
busy  output  1  FSM not in IDLE, or FIFO not empty

Behaviour:
- Reset (async, reset_n=0) sets FSM=IDLE and the FIFO empty. alu_start, alu_op, alu_a, alu_b, rsp_valid, rsp_result, rsp_op and rsp_err all go to 0. cmd_ready=1 after reset. Reset mid-operation abandons the in-flight command and all queued commands.
- FIFO: a push occurs when cmd_valid && cmd_ready. cmd_ready = !full. The full flag ignores a same-cycle pop. A push and a pop in the same cycle when not full are both performed. Count range is 0..DEPTH. Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE, FIFO non-empty: pop the head entry and latch its op/A/B into alu_op/alu_a/alu_b. If op≠000, go to ISSUE. If op=000, go directly to HOLD with rsp_result=0, rsp_err=0; no start is issued, because the ALU gives no done for NOP.
- IDLE, FIFO empty: stay in IDLE.
- ISSUE: alu_start=1 (registered) for exactly this one cycle. Go to WAIT. alu_op/alu_a/alu_b are held stable from ISSUE through the end of WAIT.
- WAIT: when alu_done=1, capture rsp_result<=alu_result, rsp_op<=alu_op, rsp_err<=0, rsp_valid<=1, and go to HOLD. Opcodes 100–111 complete normally with whatever the ALU returns (0).
- HOLD: rsp_valid, rsp_result, rsp_op and rsp_err are held stable until rsp_ready=1. On the handshake cycle, clear rsp_valid and go to IDLE.
- Latency: a command pushed at edge N into an empty FIFO with the FSM in IDLE gives alu_start high for the cycle after edge N+1. rsp_valid rises after edge N+3. A NOP gives rsp_valid after edge N+2. Steady-state throughput is one command per 4 cycles with rsp_ready held at 1.
- alu_done seen in IDLE, ISSUE or HOLD is ignored.
- busy = (state≠IDLE) || !empty.

Optional Feature:
Macro ALU_ISSUER_TIMEOUT_EN.
- Defined: a WAIT cycle counter clears on entry to WAIT. If alu_done has not been seen after TIMEOUT_CYCLES WAIT cycles, the FSM goes to HOLD with rsp_result=16'h0000, rsp_err=1 and rsp_op=the issued op. A done arriving in the same cycle as expiry takes priority as a normal completion.
- Not defined: WAIT waits indefinitely, the counter logic is absent, and rsp_err is tied to 0.

Test Plan:
- Reset release, then push ADD A=8'hFF B=8'h01 with rsp_ready=1 → single alu_start pulse; rsp_valid after 3 edges with rsp_result=16'h0100, rsp_op=001, rsp_err=0.
- Push AND 8'hF0/8'h3C, then XOR 8'hAA/8'h55 back-to-back → responses in order, 16'h0030 then 16'h00FF; exactly one start per command.
- Push NOP (000) → no alu_start; rsp_valid with rsp_result=0 after 2 edges.
- Hold rsp_ready=0 and push 5 commands (DEPTH=4) → cmd_ready drops after the FIFO fills; response 1 held stable. Releasing rsp_ready drains all commands in order.
- Assert reset_n=0 while in WAIT → all outputs 0 immediately, FIFO empty, cmd_ready=1; the next command completes normally.
- With ALU_ISSUER_TIMEOUT_EN defined and alu_done forced to 0, issue ADD → rsp_valid after 15 WAIT cycles with rsp_err=1, rsp_result=0. Without the macro, the FSM remains in WAIT.
